// File: rtl/pong_pkg.sv
// Shared encodings and defaults for the pong match-level sequencer.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } pong_state_e;

    localparam logic DIR_TO_A = 1'b0;
    localparam logic DIR_TO_B = 1'b1;

    localparam int PONG_WIN_SCORE   = 5;
    localparam int PONG_SCORE_W     = 3;
    localparam int PONG_SERVE_TICKS = 60;
    localparam int PONG_TIMER_W     = 8;

endpackage

// File: rtl/pong_edge_detect.sv
// One-cycle rising-edge detector; the previous-level register clears on async reset.
module pong_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    // Remember last cycle's level so a rise is seen exactly once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/pong_match_controller.sv
// Match sequencer: scores, serve delay, serve direction, match end.
// Optional build macro PONG_PAUSE_EN adds a pause input and paused output.
module pong_match_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = PONG_WIN_SCORE,
    parameter int SERVE_TICKS = PONG_SERVE_TICKS,
    parameter int SCORE_W     = PONG_SCORE_W
) (
    input  logic               game_clk,
    input  logic               reset,
    input  logic               start,
    input  logic               lossA,
    input  logic               lossB,
`ifdef PONG_PAUSE_EN
    input  logic               pause,
    output logic               paused,
`endif
    output logic [SCORE_W-1:0] scoreA,
    output logic [SCORE_W-1:0] scoreB,
    output logic               ball_hold,
    output logic               serve_dir,
    output logic               winnerA,
    output logic               winnerB,
    output logic [2:0]         state
);

    localparam int                    TIMER_W    = PONG_TIMER_W;
    localparam logic [TIMER_W-1:0]    SERVE_LOAD = TIMER_W'(SERVE_TICKS - 1);
    localparam logic [TIMER_W-1:0]    TIMER_ZERO = TIMER_W'(0);
    localparam logic [SCORE_W-1:0]    WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0]    SCORE_ONE  = SCORE_W'(1);
    localparam logic [SCORE_W-1:0]    SCORE_ZERO = SCORE_W'(0);

    pong_state_e          r_state;
    logic [SCORE_W-1:0]   r_score_a;
    logic [SCORE_W-1:0]   r_score_b;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_ball_hold;
    logic                 r_serve_dir;
    logic                 r_winner_a;
    logic                 r_winner_b;
    logic                 r_paused;

    pong_state_e          w_state_nxt;
    logic [SCORE_W-1:0]   w_score_a_nxt;
    logic [SCORE_W-1:0]   w_score_b_nxt;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic                 w_ball_hold_nxt;
    logic                 w_serve_dir_nxt;
    logic                 w_winner_a_nxt;
    logic                 w_winner_b_nxt;
    logic                 w_start_rise;
    logic                 w_loss_a_rise;
    logic                 w_loss_b_rise;
    logic                 w_freeze;
    logic                 w_match_won;

    pong_edge_detect u_start_edge (
        .i_clk   (game_clk),
        .i_rst_n (reset),
        .i_level (start),
        .o_rise  (w_start_rise)
    );

    pong_edge_detect u_loss_a_edge (
        .i_clk   (game_clk),
        .i_rst_n (reset),
        .i_level (lossA),
        .o_rise  (w_loss_a_rise)
    );

    pong_edge_detect u_loss_b_edge (
        .i_clk   (game_clk),
        .i_rst_n (reset),
        .i_level (lossB),
        .o_rise  (w_loss_b_rise)
    );

`ifdef PONG_PAUSE_EN
    assign w_freeze = pause & ((r_state == ST_SERVE) | (r_state == ST_PLAY));
    assign paused   = r_paused;
`else
    assign w_freeze = 1'b0;
`endif

    assign w_match_won = (r_score_a == WIN_S) | (r_score_b == WIN_S);

    // Next-state and next-output decode; illegal codes behave as IDLE.
    always_comb begin
        w_state_nxt     = r_state;
        w_score_a_nxt   = r_score_a;
        w_score_b_nxt   = r_score_b;
        w_timer_nxt     = r_timer;
        w_serve_dir_nxt = r_serve_dir;
        w_winner_a_nxt  = r_winner_a;
        w_winner_b_nxt  = r_winner_b;

        case (r_state)
            ST_SERVE: begin
                if (w_freeze) begin
                    w_timer_nxt = r_timer;
                end else if (r_timer == TIMER_ZERO) begin
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            ST_PLAY: begin
                if (w_freeze) begin
                    w_state_nxt = ST_PLAY;
                end else if (w_loss_a_rise && w_loss_b_rise) begin
                    w_state_nxt = ST_POINT;
                end else if (w_loss_a_rise) begin
                    w_score_b_nxt   = (r_score_b >= WIN_S) ? WIN_S : r_score_b + SCORE_ONE;
                    w_serve_dir_nxt = DIR_TO_A;
                    w_state_nxt     = ST_POINT;
                end else if (w_loss_b_rise) begin
                    w_score_a_nxt   = (r_score_a >= WIN_S) ? WIN_S : r_score_a + SCORE_ONE;
                    w_serve_dir_nxt = DIR_TO_B;
                    w_state_nxt     = ST_POINT;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_POINT: begin
                if (w_match_won) begin
                    w_state_nxt    = ST_OVER;
                    w_winner_a_nxt = (r_score_a == WIN_S);
                    w_winner_b_nxt = (r_score_b == WIN_S);
                end else begin
                    w_state_nxt = ST_SERVE;
                    w_timer_nxt = SERVE_LOAD;
                end
            end
            ST_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt    = ST_IDLE;
                    w_winner_a_nxt = 1'b0;
                    w_winner_b_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_OVER;
                end
            end
            default: begin
                if (w_start_rise) begin
                    w_state_nxt   = ST_SERVE;
                    w_score_a_nxt = SCORE_ZERO;
                    w_score_b_nxt = SCORE_ZERO;
                    w_timer_nxt   = SERVE_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase

        // Hold is registered together with the state it belongs to.
        w_ball_hold_nxt = (w_state_nxt != ST_PLAY) | w_freeze;
    end

    // Match state register bank.
    always_ff @(posedge game_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_score_a   <= SCORE_ZERO;
            r_score_b   <= SCORE_ZERO;
            r_timer     <= TIMER_ZERO;
            r_ball_hold <= 1'b1;
            r_serve_dir <= DIR_TO_B;
            r_winner_a  <= 1'b0;
            r_winner_b  <= 1'b0;
            r_paused    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score_a   <= w_score_a_nxt;
            r_score_b   <= w_score_b_nxt;
            r_timer     <= w_timer_nxt;
            r_ball_hold <= w_ball_hold_nxt;
            r_serve_dir <= w_serve_dir_nxt;
            r_winner_a  <= w_winner_a_nxt;
            r_winner_b  <= w_winner_b_nxt;
            r_paused    <= w_freeze;
        end
    end

    assign scoreA    = r_score_a;
    assign scoreB    = r_score_b;
    assign ball_hold = r_ball_hold;
    assign serve_dir = r_serve_dir;
    assign winnerA   = r_winner_a;
    assign winnerB   = r_winner_b;
    assign state     = r_state;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed self-checking bench for pong_match_controller (default build).
module tb_pong_match_controller;

    logic       game_clk = 1'b0;
    logic       reset    = 1'b0;
    logic       start    = 1'b0;
    logic       lossA    = 1'b0;
    logic       lossB    = 1'b0;
    logic [2:0] scoreA;
    logic [2:0] scoreB;
    logic       ball_hold;
    logic       serve_dir;
    logic       winnerA;
    logic       winnerB;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hold;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_POINT = 3;
    localparam int S_OVER  = 4;

    pong_match_controller #(
        .WIN_SCORE   (5),
        .SERVE_TICKS (60),
        .SCORE_W     (3)
    ) dut (
        .game_clk  (game_clk),
        .reset     (reset),
        .start     (start),
        .lossA     (lossA),
        .lossB     (lossB),
        .scoreA    (scoreA),
        .scoreB    (scoreB),
        .ball_hold (ball_hold),
        .serve_dir (serve_dir),
        .winnerA   (winnerA),
        .winnerB   (winnerB),
        .state     (state)
    );

    always #5 game_clk = ~game_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge game_clk);
        #1;
    endtask

    // Counts observed hold cycles until the ball is released (bounded).
    task automatic wait_hold(output int n);
        n = 0;
        while (ball_hold === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state, S_IDLE);
        check({tag, "_scoreA"}, scoreA, 0);
        check({tag, "_scoreB"}, scoreB, 0);
        check({tag, "_hold"}, ball_hold, 1);
        check({tag, "_dir"}, serve_dir, 1);
        check({tag, "_winA"}, winnerA, 0);
        check({tag, "_winB"}, winnerB, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        step();
        check_reset_values("rst");
        reset = 1'b1;
        step();
        step();
        check("idle_stay", state, S_IDLE);

        // Start -> SERVE, hold exactly 60 cycles, then PLAY toward B
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_serve", state, S_SERVE);
        wait_hold(n_hold);
        check("hold_len1", n_hold, 60);
        check("play1_state", state, S_PLAY);
        check("play1_dir", serve_dir, 1);

        // lossB rise -> point to A
        lossB = 1'b1;
        step();
        lossB = 1'b0;
        check("ptA_state", state, S_POINT);
        check("ptA_scoreA", scoreA, 1);
        check("ptA_dir", serve_dir, 1);
        check("ptA_hold", ball_hold, 1);
        step();
        check("ptA_serve", state, S_SERVE);
        wait_hold(n_hold);
        check("hold_len2", n_hold, 60);

        // Simultaneous rises -> replayed point
        lossA = 1'b1;
        lossB = 1'b1;
        step();
        lossA = 1'b0;
        lossB = 1'b0;
        check("both_state", state, S_POINT);
        check("both_scoreA", scoreA, 1);
        check("both_scoreB", scoreB, 0);
        check("both_dir", serve_dir, 1);
        step();
        check("both_serve", state, S_SERVE);
        wait_hold(n_hold);
        check("hold_len3", n_hold, 60);

        // Five lossA points -> B wins
        for (int k = 1; k <= 5; k++) begin
            lossA = 1'b1;
            step();
            lossA = 1'b0;
            check("ptB_state", state, S_POINT);
            check("ptB_score", scoreB, k);
            check("ptB_dir", serve_dir, 0);
            step();
            if (k < 5) begin
                check("ptB_serve", state, S_SERVE);
                wait_hold(n_hold);
                check("ptB_hold_len", n_hold, 60);
            end else begin
                check("over_state", state, S_OVER);
                check("over_winB", winnerB, 1);
                check("over_winA", winnerA, 0);
                check("over_hold", ball_hold, 1);
            end
        end

        // Loss edges in OVER leave the score frozen
        for (int k = 0; k < 2; k++) begin
            lossA = 1'b1;
            step();
            lossA = 1'b0;
            step();
        end
        check("over_frozen", scoreB, 5);
        check("over_stay", state, S_OVER);

        // Start held: one edge = one transition
        start = 1'b1;
        step();
        check("restart_idle", state, S_IDLE);
        check("restart_winB", winnerB, 0);
        check("restart_winA", winnerA, 0);
        step();
        step();
        check("held_start_idle", state, S_IDLE);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("second_press", state, S_SERVE);
        check("cleared_scoreA", scoreA, 0);
        check("cleared_scoreB", scoreB, 0);

        // Reset mid-SERVE with timer at 30
        for (int k = 0; k < 29; k++) begin
            step();
        end
        check("mid_serve", state, S_SERVE);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        step();
        reset = 1'b1;
        step();
        check("post_rst_idle", state, S_IDLE);

        // lossA already high at PLAY entry must not count
        start = 1'b1;
        step();
        start = 1'b0;
        lossA = 1'b1;
        wait_hold(n_hold);
        check("hold_len4", n_hold, 60);
        check("held_loss_play", state, S_PLAY);
        step();
        step();
        check("held_loss_noscore", scoreB, 0);
        check("held_loss_state", state, S_PLAY);
        lossA = 1'b0;
        step();
        lossA = 1'b1;
        step();
        lossA = 1'b0;
        check("rearm_state", state, S_POINT);
        check("rearm_score", scoreB, 1);
        check("rearm_dir", serve_dir, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
